gb_stencil_linebuf: RTL and testbench

- Parametrised line-buffer front end for the Gaussian-blur accelerator. It generalises the fixed 8-bank, 8-bit GB buffer state (bank pointer, column and row counters) to configurable lane width, image size and line count.
- It accepts one pixel per beat on an AXI-stream input and stores rows in NUM_LINES circular single-port banks.
- Once NUM_LINES-1 rows are buffered, it emits one full vertical stencil column per accepted pixel on an AXI-stream output. The downstream convolution datapath consumes these columns.

---
 rtl/gb_stencil_linebuf_if.sv | 44 ++++
 rtl/gb_stencil_linebuf.sv | 136 +++++++++++++
 tb/tb_gb_stencil_linebuf.sv | 247 ++++++++++++++++++++++++
 3 files changed

// File: rtl/gb_stencil_linebuf_if.sv
// ============================================================================
// Module      : gb_stencil_linebuf_if
// Description : Stream, handshake and status signals of the stencil line
//               buffer, with the buffer side (slave) and the driving side
//               (master) as modports.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface gb_stencil_linebuf_if #(
  parameter int DATA_W     = 8,
  parameter int IMG_WIDTH  = 488,
  parameter int IMG_HEIGHT = 648,
  parameter int NUM_LINES  = 8
);
  // Pixel input stream
  logic [DATA_W-1:0]             arg_1_TDATA;
  logic                          arg_1_TVALID;
  logic                          arg_1_TREADY;
  // Stencil column output stream
  logic [NUM_LINES*DATA_W-1:0]   arg_0_TDATA;
  logic                          arg_0_TVALID;
  logic                          arg_0_TLAST;
  logic                          arg_0_TREADY;
  // Buffer position and frame status
  logic [$clog2(NUM_LINES)-1:0]  RAM_w;
  logic [$clog2(IMG_WIDTH)-1:0]  RAM_x;
  logic [$clog2(IMG_HEIGHT)-1:0] RAM_y;
  logic                          frame_done;

  modport slave (
    input  arg_1_TDATA, arg_1_TVALID, arg_0_TREADY,
    output arg_1_TREADY, arg_0_TDATA, arg_0_TVALID, arg_0_TLAST,
           RAM_w, RAM_x, RAM_y, frame_done
  );

  modport master (
    output arg_1_TDATA, arg_1_TVALID, arg_0_TREADY,
    input  arg_1_TREADY, arg_0_TDATA, arg_0_TVALID, arg_0_TLAST,
           RAM_w, RAM_x, RAM_y, frame_done
  );
endinterface

`default_nettype wire

// File: rtl/gb_stencil_linebuf.sv
// ============================================================================
// Module      : gb_stencil_linebuf
// Description : Circular line buffer for the Gaussian-blur front end. Stores
//               rows in NUM_LINES banks and, once NUM_LINES-1 rows of the
//               frame are held, emits one vertical stencil column per
//               accepted pixel (lane 0 = oldest row, top lane = new pixel).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module gb_stencil_linebuf #(
  parameter int DATA_W     = 8,
  parameter int IMG_WIDTH  = 488,
  parameter int IMG_HEIGHT = 648,
  parameter int NUM_LINES  = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  gb_stencil_linebuf_if.slave   bus
);

  localparam int W_W   = $clog2(NUM_LINES);
  localparam int X_W   = $clog2(IMG_WIDTH);
  localparam int Y_W   = $clog2(IMG_HEIGHT);
  localparam int IDX_W = W_W + 1;
  localparam int COL_W = NUM_LINES * DATA_W;

  localparam logic [X_W-1:0] c_X_LAST  = X_W'(IMG_WIDTH - 1);
  localparam logic [Y_W-1:0] c_Y_LAST  = Y_W'(IMG_HEIGHT - 1);
  localparam logic [Y_W-1:0] c_Y_PRIME = Y_W'(NUM_LINES - 1);
  localparam logic [W_W-1:0] c_W_LAST  = W_W'(NUM_LINES - 1);

  // Bank storage: no reset, contents survive rst and are never emitted stale
  // because output is gated on the row counter of the current frame.
  logic [DATA_W-1:0] r_mem [NUM_LINES][IMG_WIDTH];

  logic [W_W-1:0]   r_w;
  logic [X_W-1:0]   r_x;
  logic [Y_W-1:0]   r_y;
  logic [COL_W-1:0] r_col;
  logic             r_valid;
  logic             r_last;
  logic             r_frame_done;

  logic             w_in_ready;
  logic             w_accept;
  logic             w_emit;
  logic             w_end_row;
  logic             w_end_frame;
  logic [IDX_W-1:0] w_idx;
  logic [COL_W-1:0] w_col;

  assign w_in_ready  = !r_valid || bus.arg_0_TREADY;
  assign w_accept    = bus.arg_1_TVALID && w_in_ready;
  assign w_emit      = w_accept && (r_y >= c_Y_PRIME);
  assign w_end_row   = (r_x == c_X_LAST);
  assign w_end_frame = w_end_row && (r_y == c_Y_LAST);

  // Assemble the column: the banks other than the one being written, oldest
  // first starting after bank w, read before this cycle's write, plus the
  // incoming pixel on the top lane.
  always_comb begin
    w_col = '0;
    w_idx = '0;
    for (int k = 0; k < NUM_LINES - 1; k++) begin
      w_idx = {1'b0, r_w} + IDX_W'(k + 1);
      if (w_idx >= IDX_W'(NUM_LINES)) begin
        w_idx = w_idx - IDX_W'(NUM_LINES);
      end
      w_col[k*DATA_W +: DATA_W] = r_mem[w_idx[W_W-1:0]][r_x];
    end
    w_col[(NUM_LINES-1)*DATA_W +: DATA_W] = bus.arg_1_TDATA;
  end

  // Bank write of the accepted pixel into bank w at column x.
  always_ff @(posedge clk) begin
    if (w_accept) begin
      r_mem[r_w][r_x] <= bus.arg_1_TDATA;
    end
  end

  // Position counters: column, row and write bank, wrapping at frame end.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_w          <= '0;
      r_x          <= '0;
      r_y          <= '0;
      r_frame_done <= 1'b0;
    end else begin
      r_frame_done <= 1'b0;
      if (w_accept) begin
        if (w_end_frame) begin
          r_x          <= '0;
          r_y          <= '0;
          r_w          <= '0;
          r_frame_done <= 1'b1;
        end else if (w_end_row) begin
          r_x <= '0;
          r_y <= r_y + 1'b1;
          r_w <= (r_w == c_W_LAST) ? '0 : r_w + 1'b1;
        end else begin
          r_x <= r_x + 1'b1;
        end
      end
    end
  end

  // Single output register: load on an emitting accept, otherwise drain on
  // downstream ready; a load in the drain cycle replaces the old column.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_col   <= '0;
      r_valid <= 1'b0;
      r_last  <= 1'b0;
    end else if (w_emit) begin
      r_col   <= w_col;
      r_valid <= 1'b1;
      r_last  <= w_end_frame;
    end else if (r_valid && bus.arg_0_TREADY) begin
      r_valid <= 1'b0;
      r_last  <= 1'b0;
    end
  end

  assign bus.arg_1_TREADY = w_in_ready;
  assign bus.arg_0_TDATA  = r_col;
  assign bus.arg_0_TVALID = r_valid;
  assign bus.arg_0_TLAST  = r_last;
  assign bus.RAM_w        = r_w;
  assign bus.RAM_x        = r_x;
  assign bus.RAM_y        = r_y;
  assign bus.frame_done   = r_frame_done;

endmodule

`default_nettype wire

// File: tb/tb_gb_stencil_linebuf.sv
// ============================================================================
// Module      : tb_gb_stencil_linebuf
// Description : Self-checking bench for gb_stencil_linebuf (W=4, H=4, N=3).
//               A frame-image model predicts every column; directed phases
//               pin literal values, a random phase stresses handshakes.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_gb_stencil_linebuf;

  localparam int DATA_W     = 8;
  localparam int IMG_WIDTH  = 4;
  localparam int IMG_HEIGHT = 4;
  localparam int NUM_LINES  = 3;
  localparam int COL_W      = NUM_LINES * DATA_W;

  logic clk;
  logic rst;

  gb_stencil_linebuf_if #(
    .DATA_W(DATA_W), .IMG_WIDTH(IMG_WIDTH),
    .IMG_HEIGHT(IMG_HEIGHT), .NUM_LINES(NUM_LINES)
  ) bus ();

  gb_stencil_linebuf #(
    .DATA_W(DATA_W), .IMG_WIDTH(IMG_WIDTH),
    .IMG_HEIGHT(IMG_HEIGHT), .NUM_LINES(NUM_LINES)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model: the current frame as a 2-D image plus the position of
  // the next pixel; expected columns queue as {last, column}.
  logic [DATA_W-1:0] img [IMG_HEIGHT][IMG_WIDTH];
  int                mx, my;
  logic [COL_W:0]    q[$];
  logic              exp_fd;
  bit                rand_ready;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic void model_reset();
    mx = 0;
    my = 0;
    q.delete();
    exp_fd = 1'b0;
  endfunction

  // Per-cycle compare at the falling edge, then advance the model by the
  // handshakes that the coming rising edge will perform.
  always @(negedge clk) begin
    if (rst) begin
      logic [COL_W-1:0] col;
      logic [DATA_W-1:0] p;
      chk("frame_done", bus.frame_done, exp_fd);
      chk("out_valid", bus.arg_0_TVALID, q.size() != 0);
      if (q.size() != 0) begin
        chk("out_data", bus.arg_0_TDATA, q[0][COL_W-1:0]);
        chk("out_last", bus.arg_0_TLAST, q[0][COL_W]);
      end
      chk("RAM_x", bus.RAM_x, mx);
      chk("RAM_y", bus.RAM_y, my);
      chk("RAM_w", bus.RAM_w, my % NUM_LINES);
      chk("in_ready", bus.arg_1_TREADY, !bus.arg_0_TVALID || bus.arg_0_TREADY);
      if (bus.arg_0_TVALID && bus.arg_0_TREADY && q.size() != 0) void'(q.pop_front());
      exp_fd = 1'b0;
      if (bus.arg_1_TVALID && bus.arg_1_TREADY) begin
        p = bus.arg_1_TDATA;
        if (my >= NUM_LINES - 1) begin
          col = '0;
          for (int k = 0; k < NUM_LINES - 1; k++)
            col[k*DATA_W +: DATA_W] = img[my - (NUM_LINES - 1) + k][mx];
          col[(NUM_LINES-1)*DATA_W +: DATA_W] = p;
          q.push_back({(mx == IMG_WIDTH - 1) && (my == IMG_HEIGHT - 1), col});
        end
        img[my][mx] = p;
        if (mx == IMG_WIDTH - 1) begin
          mx = 0;
          if (my == IMG_HEIGHT - 1) begin
            my = 0;
            exp_fd = 1'b1;
          end else begin
            my++;
          end
        end else begin
          mx++;
        end
      end
    end
  end

  // Random downstream backpressure while enabled.
  always @(posedge clk) begin
    #1;
    if (rand_ready) bus.arg_0_TREADY = 1'($urandom_range(0, 1));
  end

  // Offer one pixel and hold it until accepted (bounded).
  task automatic send(input logic [DATA_W-1:0] p);
    int n;
    bit ok;
    n  = 0;
    ok = 1'b0;
    bus.arg_1_TVALID = 1'b1;
    bus.arg_1_TDATA  = p;
    while (!ok && n < 200) begin
      @(negedge clk);
      ok = bus.arg_1_TREADY;
      @(posedge clk);
      #1;
      n++;
    end
    bus.arg_1_TVALID = 1'b0;
    if (!ok) begin
      errors++;
      $display("FAIL send_timeout: got no accept expected accept of %0h", p);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [COL_W-1:0] held;
    rst = 1'b0;
    rand_ready = 1'b0;
    bus.arg_1_TVALID = 1'b0;
    bus.arg_1_TDATA  = '0;
    bus.arg_0_TREADY = 1'b1;
    model_reset();
    #12;
    chk("rst_valid", bus.arg_0_TVALID, 0);
    chk("rst_last", bus.arg_0_TLAST, 0);
    chk("rst_data", bus.arg_0_TDATA, 0);
    chk("rst_RAM_w", bus.RAM_w, 0);
    chk("rst_RAM_x", bus.RAM_x, 0);
    chk("rst_RAM_y", bus.RAM_y, 0);
    chk("rst_fd", bus.frame_done, 0);
    chk("rst_in_ready", bus.arg_1_TREADY, 1);
    #1 rst = 1'b1;
    @(posedge clk);
    #1;

    // Prime, first column and full frame 0x00..0x0F.
    for (int i = 0; i < 8; i++) send(8'(i));
    chk("prime_RAM_w", bus.RAM_w, 2);
    chk("prime_RAM_x", bus.RAM_x, 0);
    chk("prime_RAM_y", bus.RAM_y, 2);
    chk("prime_valid", bus.arg_0_TVALID, 0);
    send(8'h08);
    chk("first_valid", bus.arg_0_TVALID, 1);
    chk("first_col", bus.arg_0_TDATA, 24'h080400);
    chk("first_last", bus.arg_0_TLAST, 0);
    for (int i = 9; i < 16; i++) send(8'(i));
    chk("last_col", bus.arg_0_TDATA, 24'h0F0B07);
    chk("last_tlast", bus.arg_0_TLAST, 1);
    chk("last_fd", bus.frame_done, 1);
    @(posedge clk);
    #1;
    chk("wrap_fd", bus.frame_done, 0);
    chk("wrap_RAM_w", bus.RAM_w, 0);
    chk("wrap_RAM_x", bus.RAM_x, 0);
    chk("wrap_RAM_y", bus.RAM_y, 0);

    // Backpressure during row 2.
    bus.arg_0_TREADY = 1'b0;
    for (int i = 0; i < 9; i++) send(8'(8'h10 + i));
    chk("bp_in_ready", bus.arg_1_TREADY, 0);
    chk("bp_col", bus.arg_0_TDATA, 24'h181410);
    held = bus.arg_0_TDATA;
    repeat (3) begin
      @(posedge clk);
      #1;
      chk("bp_stable", bus.arg_0_TDATA, held);
      chk("bp_hold_valid", bus.arg_0_TVALID, 1);
    end
    bus.arg_0_TREADY = 1'b1;
    for (int i = 9; i < 16; i++) send(8'(8'h10 + i));

    // Random frames with random gaps and backpressure.
    #2 rand_ready = 1'b1;
    for (int f = 0; f < 3; f++) begin
      for (int i = 0; i < IMG_WIDTH * IMG_HEIGHT; i++) begin
        repeat ($urandom_range(0, 2)) begin
          @(posedge clk);
          #1;
        end
        send(8'($urandom));
      end
      chk("rand_frame_RAM_w", bus.RAM_w, 0);
      chk("rand_frame_RAM_y", bus.RAM_y, 0);
    end
    #2 rand_ready = 1'b0;
    bus.arg_0_TREADY = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    chk("drain_queue", q.size(), 0);
    chk("drain_valid", bus.arg_0_TVALID, 0);

    // Async reset in row 3 with a column pending.
    for (int i = 0; i < 14; i++) send(8'(8'h40 + i));
    bus.arg_0_TREADY = 1'b0;
    chk("pend_valid", bus.arg_0_TVALID, 1);
    #2 rst = 1'b0;
    #1;
    chk("async_valid", bus.arg_0_TVALID, 0);
    chk("async_RAM_x", bus.RAM_x, 0);
    chk("async_RAM_y", bus.RAM_y, 0);
    model_reset();
    #10 rst = 1'b1;
    @(posedge clk);
    #1;
    for (int i = 0; i < 8; i++) send(8'(8'h60 + i));
    chk("post_rst_prime", bus.arg_0_TVALID, 0);
    send(8'h68);
    chk("post_rst_valid", bus.arg_0_TVALID, 1);
    chk("post_rst_col", bus.arg_0_TDATA, 24'h686460);
    bus.arg_0_TREADY = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("final_queue", q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
